inpr_fifo: RTL and testbench
============================

Name: inpr_fifo

Overview:
- Parametrised successor to the processor's single-byte input register.
- Captures external input words into a DEPTH-entry FIFO, either on value change or on an explicit strobe.
- Presents the oldest word to the processor with an input flag (FGI) and an optional interrupt request.
- Adds buffering, overflow detection and interrupt gating, so bursts are not lost while the CPU is busy.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, FIFO entries; power of 2, >=2.
- CAPTURE_MODE, 0, 0 = capture when Data_IN differs from previous-cycle sample; 1 = capture when in_strobe is high.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- Data_IN  input  WIDTH  external input word.
- in_strobe  input  1  capture request; used only when CAPTURE_MODE=1, ignored otherwise.
- flag_reset  input  1  CPU acknowledge: pop head entry (the INP instruction's flag clear).
- ien  input  1  interrupt enable level from the CPU.
- ovf_clr  input  1  clears the sticky overflow bit.
- Data_OUT  output  WIDTH  head-of-FIFO word; 0 when empty.
- flag  output  1  FGI: 1 when FIFO is non-empty.
- irq  output  1  flag & ien (combinational from registered state).
- count  output  $clog2(DEPTH+1)  number of valid entries.
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at an edge):
  - rd_ptr, wr_ptr, count = 0; flag=0; overflow=0; Data_OUT=0; irq=0.
  - Previous-sample register loaded with the current Data_IN, so no spurious capture occurs on the first cycle after reset.
  - rst has priority over every other input in the same cycle.
- Capture event (cap):
  - Mode 0: Data_IN != prev_sample.
  - Mode 1: in_strobe=1.
  - prev_sample <= Data_IN on every non-reset edge, in both modes.
- Latency:
  - A word presented in cycle N with cap=1 is written at edge N.
  - From cycle N+1: count increments, flag=1 (if previously empty), and Data_OUT shows the head.
  - Captured value is the Data_IN sampled at that edge.
- Pop (pop = flag_reset & flag):
  - At the edge, rd_ptr advances and count decrements.
  - The next entry (or 0 if now empty) appears on Data_OUT in the following cycle.
  - flag_reset while empty is ignored, with no pointer movement.
- Simultaneous cap and pop:
  - Both occur; count unchanged.
  - Valid when full: the pop frees the slot, so the push is accepted and overflow is not set.
  - Valid when empty: only the push takes effect; the new word is at the head next cycle.
- Full:
  - cap while count==DEPTH and no pop: the word is dropped, FIFO contents are unchanged, and overflow <= 1.
- Overflow:
  - Sticky until ovf_clr=1 or rst.
  - If ovf_clr and a new overflow occur in the same cycle, overflow stays 1 (set wins).
- Pointers:
  - Width $clog2(DEPTH); wrap modulo DEPTH naturally.
  - Full/empty are derived from count, not from pointer comparison.
- Data_OUT = (count!=0) ? mem[rd_ptr] : 0.
- irq = flag & ien. No edge semantics: it remains high while data is pending and ien=1.
- Memory is not cleared by reset; only pointers and count are. Data_OUT masking hides stale contents.

Decomposition:
- Shared header inpr_defs.vh:
  - CAPTURE_MODE encodings: CAP_CHANGE=0, CAP_STROBE=1.
  - clog2-based width macros for count and pointers.
- One natural sub-module, sync_fifo_ctl (WIDTH, DEPTH):
  - Contains storage, pointers, count, full/empty and the push/pop arbitration.
- inpr_fifo itself holds capture detection, overflow, flag/irq logic and Data_OUT masking.
- sync_fifo_ctl is reusable for the matching output register block.

Test Plan:
1. Reset then mode 0, WIDTH=8, DEPTH=4; Data_IN held 0x00, then 0x00 -> 0x5A at cycle 3 -> one capture; cycle 4: flag=1, count=1, Data_OUT=0x5A; holding 0x5A gives no further captures.
2. Mode 0, Data_IN 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles, no pops -> count=4, overflow=1, Data_OUT=0x11; then 4 flag_reset pulses read out 0x11, 0x22, 0x33, 0x44; flag=0 and Data_OUT=0.
3. FIFO full (4 entries), cap and flag_reset in the same cycle -> count stays 4, overflow stays 0, and the new word is read last.
4. Mode 1, Data_IN toggling every cycle, in_strobe pulsed twice with 0xA1 then 0xB2 -> exactly two entries; Data_IN changes without a strobe are ignored.
5. ien=0 with data pending -> irq=0; raise ien -> irq=1 the same cycle; pop the last entry -> irq=0 the next cycle. flag_reset on an empty FIFO leaves count=0.
6. rst asserted mid-burst with count=3 and overflow=1 -> next cycle count=0, flag=0, overflow=0, Data_OUT=0; no capture on the first post-reset cycle even though Data_IN is nonzero.

Source files
------------

// File: rtl/inpr_fifo_pkg.sv
// Shared constants and width helpers for the buffered input register.
// Capture-mode encodings and count/pointer width functions.
package inpr_fifo_pkg;

  localparam int CAP_CHANGE = 0;
  localparam int CAP_STROBE = 1;

  function automatic int cnt_w(int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/inpr_fifo_sync_fifo_ctl.sv
// Synchronous FIFO storage, pointers, count and push/pop arbitration.
// Reusable for the matching output register block.
module sync_fifo_ctl
  import inpr_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH),
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case (1'b1)
        push_ok & ~pop_ok: count <= count + CW'(1);
        pop_ok & ~push_ok: count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inpr_fifo.sv
// Buffered processor input register: capture, overflow, FGI and irq.
// Head word is masked to zero while the FIFO is empty.
module inpr_fifo
  import inpr_fifo_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int CAPTURE_MODE = CAP_CHANGE,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Data_IN,
  input  logic             in_strobe,
  input  logic             flag_reset,
  input  logic             ien,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] Data_OUT,
  output logic             flag,
  output logic             irq,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] prev_sample;
  logic [WIDTH-1:0] head;
  logic             cap;
  logic             full;
  logic             empty;
  logic             drop;

  assign cap = (CAPTURE_MODE == CAP_STROBE) ? in_strobe
                                            : (Data_IN != prev_sample);

  sync_fifo_ctl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cap),
    .pop     (flag_reset),
    .wr_data (Data_IN),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .drop    (drop)
  );

  // Reset loads the live input so the first cycle sees no change.
  always_ff @(posedge clk) begin
    prev_sample <= Data_IN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign flag     = ~empty;
  assign irq      = flag & ien;
  assign Data_OUT = empty ? '0 : head;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_inpr_fifo.sv
// Bench for inpr_fifo: change-capture and strobe-capture instances
// checked against a shift-array model plus directed literal checks.
module tb_inpr_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Data_IN;
  logic       in_strobe;
  logic       flag_reset;
  logic       ien;
  logic       ovf_clr;

  logic [7:0] dout [2];
  logic       flg  [2];
  logic       irqo [2];
  logic [2:0] cnt  [2];
  logic       ovf  [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_q   [2][4];
  int         m_n   [2];
  bit         m_ovf [2];
  logic [7:0] m_prev;

  logic [7:0] v2 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] v3 [4] = '{8'h62, 8'h63, 8'h64, 8'h65};

  always #5 clk = ~clk;

  inpr_fifo #(.WIDTH(8), .DEPTH(4), .CAPTURE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .Data_IN(Data_IN), .in_strobe(in_strobe),
    .flag_reset(flag_reset), .ien(ien), .ovf_clr(ovf_clr),
    .Data_OUT(dout[0]), .flag(flg[0]), .irq(irqo[0]),
    .count(cnt[0]), .overflow(ovf[0])
  );

  inpr_fifo #(.WIDTH(8), .DEPTH(4), .CAPTURE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .Data_IN(Data_IN), .in_strobe(in_strobe),
    .flag_reset(flag_reset), .ien(ien), .ovf_clr(ovf_clr),
    .Data_OUT(dout[1]), .flag(flg[1]), .irq(irqo[1]),
    .count(cnt[1]), .overflow(ovf[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic model_step();
    bit cap;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        m_n[m]   = 0;
        m_ovf[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        cap = (m == 1) ? in_strobe : (Data_IN != m_prev);
        if (flag_reset && m_n[m] > 0) begin
          for (int k = 0; k < 3; k++) m_q[m][k] = m_q[m][k+1];
          m_n[m]--;
        end
        if (cap && m_n[m] < 4) begin
          m_q[m][m_n[m]] = Data_IN;
          m_n[m]++;
        end else if (cap) begin
          m_ovf[m] = 1'b1;
        end else if (ovf_clr) begin
          m_ovf[m] = 1'b0;
        end
      end
    end
    m_prev = Data_IN;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int m = 0; m < 2; m++) begin
          chk($sformatf("m%0d count", m), 32'(cnt[m]), 32'(m_n[m]));
          chk($sformatf("m%0d flag", m), 32'(flg[m]), 32'(m_n[m] > 0));
          chk($sformatf("m%0d ovf", m), 32'(ovf[m]), 32'(m_ovf[m]));
          chk($sformatf("m%0d irq", m), 32'(irqo[m]),
              32'((m_n[m] > 0) && ien));
          chk($sformatf("m%0d dout", m), 32'(dout[m]),
              (m_n[m] > 0) ? 32'(m_q[m][0]) : 32'h0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; Data_IN = 8'h00; in_strobe = 1'b0;
    flag_reset = 1'b0; ien = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    settle();
    chk("rst count", 32'(cnt[0]), 0);
    chk("rst dout", 32'(dout[0]), 0);

    tick(); tick(); tick();
    chk("t1 idle", 32'(cnt[0]), 0);
    Data_IN = 8'h5A;
    tick(); settle();
    chk("t1 count", 32'(cnt[0]), 1);
    chk("t1 flag", 32'(flg[0]), 1);
    chk("t1 dout", 32'(dout[0]), 32'h5A);
    chk("t1 m1 none", 32'(cnt[1]), 0);
    tick(); tick();
    chk("t1 hold", 32'(cnt[0]), 1);
    flag_reset = 1'b1;
    tick();
    flag_reset = 1'b0; settle();
    chk("t1 pop", 32'(cnt[0]), 0);

    for (int i = 0; i < 5; i++) begin
      Data_IN = v2[i];
      tick();
    end
    settle();
    chk("t2 count", 32'(cnt[0]), 4);
    chk("t2 ovf", 32'(ovf[0]), 1);
    chk("t2 head", 32'(dout[0]), 32'h11);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2 rd%0d", i), 32'(dout[0]), 32'(v2[i]));
      flag_reset = 1'b1;
      tick();
    end
    flag_reset = 1'b0; settle();
    chk("t2 flag", 32'(flg[0]), 0);
    chk("t2 dout0", 32'(dout[0]), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0; settle();
    chk("t2 ovfclr", 32'(ovf[0]), 0);

    for (int i = 0; i < 4; i++) begin
      Data_IN = 8'h61 + 8'(i);
      tick();
    end
    Data_IN = 8'h65; flag_reset = 1'b1;
    tick();
    flag_reset = 1'b0; settle();
    chk("t3 count", 32'(cnt[0]), 4);
    chk("t3 ovf", 32'(ovf[0]), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3 rd%0d", i), 32'(dout[0]), 32'(v3[i]));
      flag_reset = 1'b1;
      tick();
    end
    flag_reset = 1'b0; settle();
    chk("t3 empty", 32'(cnt[0]), 0);

    for (int i = 0; i < 8; i++) begin
      Data_IN = (i == 2) ? 8'hA1 : (i == 5) ? 8'hB2 :
                (i % 2 == 1) ? 8'h3C : 8'hC3;
      in_strobe = (i == 2) || (i == 5);
      tick();
    end
    in_strobe = 1'b0; settle();
    chk("t4 count", 32'(cnt[1]), 2);
    chk("t4 head", 32'(dout[1]), 32'hA1);
    flag_reset = 1'b1;
    tick(); settle();
    chk("t4 second", 32'(dout[1]), 32'hB2);
    tick();
    flag_reset = 1'b0; settle();
    chk("t4 empty", 32'(cnt[1]), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    ien = 1'b0; Data_IN = 8'h77; in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0; settle();
    chk("t5 irq off", 32'(irqo[0]), 0);
    chk("t5 flag", 32'(flg[0]), 1);
    ien = 1'b1; settle();
    chk("t5 irq0 on", 32'(irqo[0]), 1);
    chk("t5 irq1 on", 32'(irqo[1]), 1);
    flag_reset = 1'b1;
    tick();
    flag_reset = 1'b0; settle();
    chk("t5 irq pop", 32'(irqo[0]), 0);
    flag_reset = 1'b1;
    tick();
    flag_reset = 1'b0; settle();
    chk("t5 empty pop", 32'(cnt[0]), 0);

    for (int i = 0; i < 5; i++) begin
      Data_IN = 8'h31 + 8'(i);
      tick();
    end
    flag_reset = 1'b1;
    tick();
    flag_reset = 1'b0; settle();
    chk("t6 count", 32'(cnt[0]), 3);
    chk("t6 ovf", 32'(ovf[0]), 1);
    Data_IN = 8'h99; rst = 1'b1;
    tick();
    rst = 1'b0; settle();
    chk("t6 count", 32'(cnt[0]), 0);
    chk("t6 flag", 32'(flg[0]), 0);
    chk("t6 ovf", 32'(ovf[0]), 0);
    chk("t6 dout", 32'(dout[0]), 0);
    tick(); settle();
    chk("t6 nocap", 32'(cnt[0]), 0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
